pid_filtered_ctrl: RTL and testbench

//  Discrete PID controller with a first-order filtered derivative, integrator anti-windup and output saturation.

---
 rtl/pid_filtered_ctrl.sv | 128 ++++++++++++
 tb/tb_pid_filtered_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_filtered_ctrl.sv
// PID controller with first-order filtered derivative, independent integrator clamp and output clamp.
// Latency: out registers at the en edge that samples in; vld pulses for the cycle after that edge.
// Backpressure: none; every en pulse is one sample, and all state holds while en is low.
module pid_filtered_ctrl #(
    parameter int  DW    = 48,
    parameter int  FW    = 24,
    parameter int  W     = 36,
    parameter real P     = 39.0,
    parameter real I     = 2.35,
    parameter real D     = 1.1e-3,
    parameter real N     = 1.64e5,
    parameter real TS    = 1.0e-5,
    parameter int  LIMIT = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic signed [DW-1:0] in,
    output logic signed [DW-1:0] out,
    output logic                 vld
);

    // Intermediate width: a full DW x W product plus sign/difference headroom,
    // so no product or sum can wrap before it is clamped.
    localparam int  XW    = DW + W + 2;
    localparam real SCALE = 2.0 ** FW;
    localparam real A_R   = 1.0 / (1.0 + N * TS);
    localparam real B_R   = D * N / (1.0 + N * TS);

    // Coefficients quantised to W bits, round-to-nearest.
    localparam longint KP_L = longint'(P * SCALE);
    localparam longint KI_L = longint'(I * SCALE);
    localparam longint A_L  = longint'(A_R * SCALE);
    localparam longint B_L  = longint'(B_R * SCALE);

    localparam logic signed [W-1:0] KP_C = W'(KP_L);
    localparam logic signed [W-1:0] KI_C = W'(KI_L);
    localparam logic signed [W-1:0] A_C  = W'(A_L);
    localparam logic signed [W-1:0] B_C  = W'(B_L);

    localparam logic signed [XW-1:0] KP_X = XW'(KP_C);
    localparam logic signed [XW-1:0] KI_X = XW'(KI_C);
    localparam logic signed [XW-1:0] A_X  = XW'(A_C);
    localparam logic signed [XW-1:0] B_X  = XW'(B_C);

    // Clamp bounds: +-LIMIT in Q format, and the full DW range for the
    // derivative state so a huge error step cannot wrap it.
    localparam logic signed [XW-1:0] LIM_X = XW'(LIMIT) <<< FW;
    localparam logic signed [XW-1:0] D_MAX = XW'({1'b0, {(DW-1){1'b1}}});
    localparam logic signed [XW-1:0] D_MIN = ~D_MAX;

    function automatic logic signed [DW-1:0] clamp(
        input logic signed [XW-1:0] v,
        input logic signed [XW-1:0] lo,
        input logic signed [XW-1:0] hi
    );
        if (v > hi) begin
            return hi[DW-1:0];
        end else if (v < lo) begin
            return lo[DW-1:0];
        end else begin
            return v[DW-1:0];
        end
    endfunction

    logic signed [DW-1:0] e_prev_q, e_prev_d;
    logic signed [DW-1:0] i_q, i_d;
    logic signed [DW-1:0] d_q, d_d;
    logic signed [DW-1:0] out_q, out_d;
    logic                 vld_q, vld_d;

    logic signed [XW-1:0] e_x, ep_x, i_x, d_x;
    logic signed [XW-1:0] p_kp, p_ki, p_a, p_b;
    logic signed [DW-1:0] i_new, d_new, o_new;

    // Sample datapath: floor-shifted products, integrator clamped before it
    // feeds the output sum so a reversed error acts immediately.
    always_comb begin
        e_x   = XW'(in);
        ep_x  = XW'(e_prev_q);
        i_x   = XW'(i_q);
        d_x   = XW'(d_q);
        p_kp  = (KP_X * e_x) >>> FW;
        p_ki  = (KI_X * e_x) >>> FW;
        p_a   = (A_X * d_x) >>> FW;
        p_b   = (B_X * (e_x - ep_x)) >>> FW;
        i_new = clamp(i_x + p_ki, -LIM_X, LIM_X);
        d_new = clamp(p_a + p_b, D_MIN, D_MAX);
        o_new = clamp(p_kp + XW'(i_new) + XW'(d_new), -LIM_X, LIM_X);
    end

    // Next state: take the new sample on en, otherwise hold everything.
    always_comb begin
        e_prev_d = e_prev_q;
        i_d      = i_q;
        d_d      = d_q;
        out_d    = out_q;
        vld_d    = 1'b0;
        if (en) begin
            e_prev_d = in;
            i_d      = i_new;
            d_d      = d_new;
            out_d    = o_new;
            vld_d    = 1'b1;
        end
    end

    // State registers, cleared asynchronously so reset aborts any sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_prev_q <= '0;
            i_q      <= '0;
            d_q      <= '0;
            out_q    <= '0;
            vld_q    <= 1'b0;
        end else begin
            e_prev_q <= e_prev_d;
            i_q      <= i_d;
            d_q      <= d_d;
            out_q    <= out_d;
            vld_q    <= vld_d;
        end
    end

    assign out = out_q;
    assign vld = vld_q;

endmodule

// File: tb/tb_pid_filtered_ctrl.sv
// Bench for pid_filtered_ctrl: real-valued reference model feeding an expected-value queue.
// Each strobe pushes the model result; the result is popped when vld appears.
// Strobes are spaced two cycles apart; every wait is bounded to a fixed window.
module tb_pid_filtered_ctrl;

    localparam int  DW    = 48;
    localparam real SCALE = 16777216.0;
    localparam real KP_R  = 39.0;
    localparam real KI_R  = 2.35;
    localparam real A_R   = 1.0 / (1.0 + 1.64e5 * 1.0e-5);
    localparam real B_R   = 1.1e-3 * 1.64e5 / (1.0 + 1.64e5 * 1.0e-5);
    localparam real LIM   = 1000.0;
    localparam real TOL   = 1.0e-3;
    localparam real SPEC_TOL = 1.0e-2;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 en    = 1'b0;
    logic signed [DW-1:0] in    = '0;
    logic signed [DW-1:0] out;
    logic                 vld;
    bit                   clk_run = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    real exp_q[$];
    bit  exact_q[$];
    real m_ep = 0.0;
    real m_i  = 0.0;
    real m_d  = 0.0;

    pid_filtered_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .in    (in),
        .out   (out),
        .vld   (vld)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    function automatic logic signed [DW-1:0] to_q(input real r);
        return DW'(longint'(r * SCALE));
    endfunction

    function automatic real to_r(input logic signed [DW-1:0] v);
        return real'(longint'(v)) / SCALE;
    endfunction

    function automatic real rabs(input real r);
        return (r < 0.0) ? -r : r;
    endfunction

    function automatic real rsat(input real r);
        if (r > LIM) return LIM;
        if (r < -LIM) return -LIM;
        return r;
    endfunction

    function automatic real model_step(input real e);
        m_i  = rsat(m_i + KI_R * e);
        m_d  = A_R * m_d + B_R * (e - m_ep);
        m_ep = e;
        return rsat(KP_R * e + m_i + m_d);
    endfunction

    function automatic void model_reset();
        m_ep = 0.0;
        m_i  = 0.0;
        m_d  = 0.0;
    endfunction

    // One strobe: push the model's answer, then over a two-cycle window
    // require exactly one vld pulse and pop/compare at that pulse.
    task automatic sample(input real e_r, input bit exact, input string tag);
        int                   pulses;
        logic signed [DW-1:0] got;
        real                  ev;
        bit                   ex;
        in = to_q(e_r);
        en = 1'b1;
        exp_q.push_back(model_step(e_r));
        exact_q.push_back(exact);
        @(posedge clk);
        #1;
        en = 1'b0;
        pulses = 0;
        got = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (vld === 1'b1) begin
                pulses++;
                if (pulses == 1) got = out;
            end
        end
        ev = exp_q.pop_front();
        ex = exact_q.pop_front();
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL %s vld_pulses: got %0d, need 1", tag, pulses);
        end else begin
            n_checks++;
            if (ex) begin
                if (got !== to_q(ev)) begin
                    n_fail++;
                    $display("FAIL %s out_exact: got %f, need %f", tag, to_r(got), ev);
                end
            end else if ($isunknown(got) || rabs(to_r(got) - ev) > TOL) begin
                n_fail++;
                $display("FAIL %s out: got %f, need %f", tag, to_r(got), ev);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out !== '0 || vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: out=%h vld=%b, need out=0 vld=0", out, vld);
        end
        #5;
        rst_n = 1'b1;
        clk_run = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (out !== '0 || vld !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle: out=%h vld=%b, need out=0 vld=0", out, vld);
            end
        end
    endtask

    task automatic test_step();
        sample(1.0, 1'b0, "step1");
        n_checks++;
        if (rabs(to_r(out) - 109.68) > SPEC_TOL) begin
            n_fail++;
            $display("FAIL step1_value: got %f, need 109.68", to_r(out));
        end
        sample(1.0, 1'b0, "step2");
        n_checks++;
        if (rabs(to_r(out) - 69.58) > SPEC_TOL) begin
            n_fail++;
            $display("FAIL step2_value: got %f, need 69.58", to_r(out));
        end
    endtask

    task automatic test_hold();
        logic signed [DW-1:0] held;
        held = out;
        for (int k = 0; k < 6; k++) begin
            in = DW'({$urandom, $urandom});
            @(negedge clk);
            n_checks++;
            if (out !== held || vld !== 1'b0) begin
                n_fail++;
                $display("FAIL hold: out=%f vld=%b, need out=%f vld=0", to_r(out), vld, to_r(held));
            end
        end
        sample(1.0, 1'b0, "hold_resume");
    endtask

    task automatic test_back_to_back();
        real pat[5];
        pat = '{0.5, -0.25, 3.0, -2.0, 0.0};
        for (int k = 0; k < 5; k++) begin
            sample(pat[k], 1'b0, "b2b");
        end
    endtask

    task automatic test_saturation();
        sample(100.0, 1'b1, "sat_pos");
        n_checks++;
        if (out !== to_q(1000.0)) begin
            n_fail++;
            $display("FAIL sat_pos_value: got %f, need 1000.0", to_r(out));
        end
        sample(-100.0, 1'b1, "sat_neg");
        n_checks++;
        if (out !== to_q(-1000.0)) begin
            n_fail++;
            $display("FAIL sat_neg_value: got %f, need -1000.0", to_r(out));
        end
    endtask

    task automatic test_anti_windup();
        do_reset();
        for (int k = 0; k < 500; k++) begin
            sample(1.0, 1'b0, "windup");
        end
        sample(-1.0, 1'b0, "reverse");
        n_checks++;
        if (rabs(to_r(out) - 821.98) > SPEC_TOL) begin
            n_fail++;
            $display("FAIL reverse_value: got %f, need 821.98", to_r(out));
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        sample(1.0, 1'b0, "mid_pre");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (out !== '0 || vld !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_clear: out=%h vld=%b, need 0/0", out, vld);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sample(1.0, 1'b0, "mid_post");
        n_checks++;
        if (rabs(to_r(out) - 109.68) > SPEC_TOL) begin
            n_fail++;
            $display("FAIL mid_post_value: got %f, need 109.68", to_r(out));
        end
    endtask

    initial begin
        test_reset();
        @(posedge clk);
        #1;
        test_step();
        test_hold();
        test_back_to_back();
        test_saturation();
        test_anti_windup();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
